// File: rtl/wb_arbiter_2m.sv
// -----------------------------------------------------------------------------
// wb_arbiter_2m
//
// Two-master to one-slave Wishbone classic (B3) arbiter. M0 is the CPU
// instruction-fetch master and M1 the data master. Ownership is granted
// round-robin and held for as long as the owner keeps CYC asserted, so
// multi-beat and read-modify-write sequences are never split. A watchdog
// ends any strobed access that the slave leaves unanswered for TIMEOUT
// cycles by returning ERR to the owner.
//
// Ports:
//   i_clk, i_reset_n              clock, asynchronous active-low reset
//   i_mX_cyc/stb/we/addr/data/sel master X request (X = 0, 1)
//   o_mX_data/ack/err             master X response
//   o_s_cyc/stb/we/addr/data/sel  request towards the shared slave
//   i_s_data/ack/err              slave response
//   o_grant                       one-hot owner (01 = M0, 10 = M1, 00 = none)
// -----------------------------------------------------------------------------
module wb_arbiter_2m #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            i_clk,
    input  logic            i_reset_n,

    input  logic            i_m0_cyc,
    input  logic            i_m0_stb,
    input  logic            i_m0_we,
    input  logic [AW-1:0]   i_m0_addr,
    input  logic [DW-1:0]   i_m0_data,
    input  logic [DW/8-1:0] i_m0_sel,
    output logic [DW-1:0]   o_m0_data,
    output logic            o_m0_ack,
    output logic            o_m0_err,

    input  logic            i_m1_cyc,
    input  logic            i_m1_stb,
    input  logic            i_m1_we,
    input  logic [AW-1:0]   i_m1_addr,
    input  logic [DW-1:0]   i_m1_data,
    input  logic [DW/8-1:0] i_m1_sel,
    output logic [DW-1:0]   o_m1_data,
    output logic            o_m1_ack,
    output logic            o_m1_err,

    output logic            o_s_cyc,
    output logic            o_s_stb,
    output logic            o_s_we,
    output logic [AW-1:0]   o_s_addr,
    output logic [DW-1:0]   o_s_data,
    output logic [DW/8-1:0] o_s_sel,
    input  logic [DW-1:0]   i_s_data,
    input  logic            i_s_ack,
    input  logic            i_s_err,

    output logic [1:0]      o_grant
);

    // The counter holds the number of stalled cycles already seen, so it
    // never has to represent more than TIMEOUT-1.
    localparam int            CW    = $clog2(TIMEOUT);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2,
        TOUT = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic          last_q, last_d;      // 0: M0 owned last, 1: M1 owned last
    logic [CW-1:0] count_q, count_d;

    // Owner's CYC/STB; only meaningful in OWN0/OWN1.
    logic own_cyc;
    logic own_stb;
    logic stalled;

    assign own_cyc = (state_q == OWN0) ? i_m0_cyc : i_m1_cyc;
    assign own_stb = (state_q == OWN0) ? i_m0_stb : i_m1_stb;
    assign stalled = own_stb && !i_s_ack && !i_s_err;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of process ordering.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= IDLE;
            last_q  <= 1'b1;          // M0 wins the first tie after reset
            count_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            count_q <= count_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every signal assigned here gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        count_d = '0;

        case (state_q)
            IDLE: begin
                // On a tie, grant the master that did not own the bus last.
                if (i_m0_cyc && (!i_m1_cyc || last_q)) begin
                    state_d = OWN0;
                    last_d  = 1'b0;
                end else if (i_m1_cyc) begin
                    state_d = OWN1;
                    last_d  = 1'b1;
                end
            end

            OWN0, OWN1: begin
                // Releasing CYC wins over a watchdog expiry in the same cycle.
                if (!own_cyc) begin
                    state_d = IDLE;
                end else if (stalled) begin
                    if (count_q == LIMIT) begin
                        state_d = TOUT;
                    end else begin
                        count_d = count_q + CW'(1);
                    end
                end
            end

            TOUT:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Output logic: pure function of state plus the owner's / slave's signals.
    // The non-owner never sees anything, which also rules out any path from
    // one master's inputs to the other master's outputs.
    // -------------------------------------------------------------------------
    always_comb begin
        o_s_cyc   = 1'b0;
        o_s_stb   = 1'b0;
        o_s_we    = 1'b0;
        o_s_addr  = '0;
        o_s_data  = '0;
        o_s_sel   = '0;
        o_m0_data = '0;
        o_m0_ack  = 1'b0;
        o_m0_err  = 1'b0;
        o_m1_data = '0;
        o_m1_ack  = 1'b0;
        o_m1_err  = 1'b0;
        o_grant   = 2'b00;

        case (state_q)
            OWN0: begin
                o_s_cyc   = i_m0_cyc;
                o_s_stb   = i_m0_stb;
                o_s_we    = i_m0_we;
                o_s_addr  = i_m0_addr;
                o_s_data  = i_m0_data;
                o_s_sel   = i_m0_sel;
                o_m0_data = i_s_data;
                o_m0_ack  = i_s_ack;
                o_m0_err  = i_s_err;
                o_grant   = 2'b01;
            end

            OWN1: begin
                o_s_cyc   = i_m1_cyc;
                o_s_stb   = i_m1_stb;
                o_s_we    = i_m1_we;
                o_s_addr  = i_m1_addr;
                o_s_data  = i_m1_data;
                o_s_sel   = i_m1_sel;
                o_m1_data = i_s_data;
                o_m1_ack  = i_s_ack;
                o_m1_err  = i_s_err;
                o_grant   = 2'b10;
            end

            // The slave is cut off; a late ACK/ERR is not forwarded. The
            // synthetic ERR goes to whoever owned the bus (last_q).
            TOUT: begin
                if (last_q) begin
                    o_m1_err = 1'b1;
                end else begin
                    o_m0_err = 1'b1;
                end
            end

            default: ;
        endcase
    end

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// -----------------------------------------------------------------------------
// tb_wb_arbiter_2m
//
// Drives wb_arbiter_2m (TIMEOUT = 4) through a directed sequence followed by
// randomized master/slave traffic with occasional asynchronous resets. A
// behavioural model of bus ownership predicts every output each cycle.
// -----------------------------------------------------------------------------
module tb_wb_arbiter_2m;

    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int TIMEOUT = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    logic            m_cyc   [2];
    logic            m_stb   [2];
    logic            m_we    [2];
    logic [AW-1:0]   m_addr  [2];
    logic [DW-1:0]   m_wdata [2];
    logic [DW/8-1:0] m_sel   [2];
    logic [DW-1:0]   m_rdata [2];
    logic            m_ack   [2];
    logic            m_err   [2];

    logic            o_s_cyc, o_s_stb, o_s_we;
    logic [AW-1:0]   o_s_addr;
    logic [DW-1:0]   o_s_data;
    logic [DW/8-1:0] o_s_sel;
    logic [DW-1:0]   s_rdata;
    logic            s_ack, s_err;
    logic [1:0]      o_grant;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    wb_arbiter_2m #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .i_m0_cyc  (m_cyc[0]),
        .i_m0_stb  (m_stb[0]),
        .i_m0_we   (m_we[0]),
        .i_m0_addr (m_addr[0]),
        .i_m0_data (m_wdata[0]),
        .i_m0_sel  (m_sel[0]),
        .o_m0_data (m_rdata[0]),
        .o_m0_ack  (m_ack[0]),
        .o_m0_err  (m_err[0]),
        .i_m1_cyc  (m_cyc[1]),
        .i_m1_stb  (m_stb[1]),
        .i_m1_we   (m_we[1]),
        .i_m1_addr (m_addr[1]),
        .i_m1_data (m_wdata[1]),
        .i_m1_sel  (m_sel[1]),
        .o_m1_data (m_rdata[1]),
        .o_m1_ack  (m_ack[1]),
        .o_m1_err  (m_err[1]),
        .o_s_cyc   (o_s_cyc),
        .o_s_stb   (o_s_stb),
        .o_s_we    (o_s_we),
        .o_s_addr  (o_s_addr),
        .o_s_data  (o_s_data),
        .o_s_sel   (o_s_sel),
        .i_s_data  (s_rdata),
        .i_s_ack   (s_ack),
        .i_s_err   (s_err),
        .o_grant   (o_grant)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled
    // on the falling edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic idle_master(input int k);
        m_cyc[k]   = 1'b0;
        m_stb[k]   = 1'b0;
        m_we[k]    = 1'b0;
        m_addr[k]  = '0;
        m_wdata[k] = '0;
        m_sel[k]   = '0;
    endtask

    // -------------------------------------------------------------------------
    // Reference model: who owns the bus, whether we are in the one-cycle
    // timeout response, who was served last, and how long the current
    // strobe has gone unanswered.
    // -------------------------------------------------------------------------
    int mdl_owner   = -1;   // -1: nobody
    bit mdl_timeout = 1'b0;
    int mdl_last    = 1;    // M1 "served last" so M0 wins the first tie
    int mdl_wait    = 0;

    initial begin : model
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                mdl_owner   = -1;
                mdl_timeout = 1'b0;
                mdl_last    = 1;
                mdl_wait    = 0;
            end else if (mdl_timeout) begin
                mdl_timeout = 1'b0;
                mdl_owner   = -1;
                mdl_wait    = 0;
            end else if (mdl_owner < 0) begin
                if (m_cyc[0] && m_cyc[1]) mdl_owner = 1 - mdl_last;
                else if (m_cyc[0])        mdl_owner = 0;
                else if (m_cyc[1])        mdl_owner = 1;
                if (mdl_owner >= 0) mdl_last = mdl_owner;
                mdl_wait = 0;
            end else if (!m_cyc[mdl_owner]) begin
                mdl_owner = -1;
                mdl_wait  = 0;
            end else if (m_stb[mdl_owner] && !s_ack && !s_err) begin
                mdl_wait++;
                if (mdl_wait == TIMEOUT) begin
                    mdl_timeout = 1'b1;
                    mdl_wait    = 0;
                end
            end else begin
                mdl_wait = 0;
            end
        end
    end

    // Every cycle: compare grant, slave-side bundle and both master responses.
    initial begin : compare
        logic [1:0]  exp_grant;
        logic [70:0] exp_s;
        logic [33:0] exp_m [2];
        bit          active;
        forever begin
            settle();
            active    = (mdl_owner >= 0) && !mdl_timeout;
            exp_grant = 2'b00;
            exp_s     = '0;
            exp_m[0]  = '0;
            exp_m[1]  = '0;
            if (active) begin
                exp_grant = (mdl_owner == 0) ? 2'b01 : 2'b10;
                exp_s = {m_cyc[mdl_owner], m_stb[mdl_owner], m_we[mdl_owner],
                         m_addr[mdl_owner], m_wdata[mdl_owner], m_sel[mdl_owner]};
                exp_m[mdl_owner] = {s_ack, s_err, s_rdata};
            end else if (mdl_timeout) begin
                exp_m[mdl_owner] = {1'b0, 1'b1, 32'h0};
            end
            check("grant", o_grant, exp_grant);
            check("slave_bus", {o_s_cyc, o_s_stb, o_s_we, o_s_addr, o_s_data, o_s_sel}, exp_s);
            check("m0_resp", {m_ack[0], m_err[0], m_rdata[0]}, exp_m[0]);
            check("m1_resp", {m_ack[1], m_err[1], m_rdata[1]}, exp_m[1]);
        end
    end

    // -------------------------------------------------------------------------
    // Stimulus with hand-computed expectations
    // -------------------------------------------------------------------------
    initial begin : stimulus
        int writes;
        int stb_cycles;
        int hold [2];
        int stall;
        bit rst_pending;

        idle_master(0);
        idle_master(1);
        s_ack   = 1'b0;
        s_err   = 1'b0;
        s_rdata = '0;

        step();
        step();
        settle();
        check("rst_grant", o_grant, 2'b00);
        check("rst_s_cyc", o_s_cyc, 1'b0);

        // ---- M0 read at 0x100, slave acks on its 2nd cycle ----
        step();
        rst_n     = 1'b1;
        m_cyc[0]  = 1'b1;
        m_stb[0]  = 1'b1;
        m_addr[0] = 32'h100;
        m_sel[0]  = 4'hf;
        settle();
        check("t1_idle_grant", o_grant, 2'b00);
        step();
        settle();
        check("t1_grant", o_grant, 2'b01);
        check("t1_s_addr", o_s_addr, 32'h100);
        check("t1_no_ack_yet", m_ack[0], 1'b0);
        step();
        s_ack   = 1'b1;
        s_rdata = 32'hcafe_0001;
        settle();
        check("t1_m0_ack", m_ack[0], 1'b1);
        check("t1_m0_data", m_rdata[0], 32'hcafe_0001);
        check("t1_m1_ack", m_ack[1], 1'b0);
        step();
        idle_master(0);
        s_ack = 1'b0;
        settle();
        check("t1_release_s_cyc", o_s_cyc, 1'b0);
        step();
        settle();
        check("t1_back_idle", o_grant, 2'b00);

        // ---- Reset pulsed in the middle of an M0 transfer ----
        step();
        m_cyc[0]  = 1'b1;
        m_stb[0]  = 1'b1;
        m_addr[0] = 32'h200;
        step();
        s_ack   = 1'b1;
        s_rdata = 32'h1234_5678;
        #1;
        check("t5_pre_ack", m_ack[0], 1'b1);
        rst_n = 1'b0;
        #1;
        check("t5_rst_grant", o_grant, 2'b00);
        check("t5_rst_s_cyc", o_s_cyc, 1'b0);
        check("t5_rst_m0_ack", m_ack[0], 1'b0);
        idle_master(0);
        s_ack = 1'b0;
        step();
        step();
        rst_n = 1'b1;

        // ---- Tie after reset: M0 first, then M1, then M0 again ----
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_addr[0] = 32'h300;
        m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_addr[1] = 32'h400;
        settle();
        check("t2_idle", o_grant, 2'b00);
        step();
        settle();
        check("t2_m0_first", o_grant, 2'b01);
        check("t2_m0_addr", o_s_addr, 32'h300);
        step();
        idle_master(0);
        settle();
        step();
        settle();
        check("t2_handover_idle", o_grant, 2'b00);
        check("t2_handover_stb", o_s_stb, 1'b0);
        step();
        settle();
        check("t2_m1_second", o_grant, 2'b10);
        check("t2_m1_addr", o_s_addr, 32'h400);
        step();
        idle_master(1);
        step();
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_addr[0] = 32'h304;
        m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_addr[1] = 32'h404;
        settle();
        check("t2_idle2", o_grant, 2'b00);
        step();
        settle();
        check("t2_tie2_m0", o_grant, 2'b01);
        step();
        idle_master(0);
        step();
        step();
        settle();
        check("t2_tie2_m1", o_grant, 2'b10);
        step();
        idle_master(1);
        step();

        // ---- M1 locks the bus for three writes while M0 waits ----
        m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_we[1] = 1'b1; m_sel[1] = 4'hf;
        m_addr[1] = 32'h10;
        step();
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_addr[0] = 32'h500;
        writes = 0;
        for (int i = 0; i < 3; i++) begin
            m_addr[1]  = 32'h10 + 32'(4 * i);
            m_wdata[1] = 32'hd000 + 32'(i);
            s_ack      = 1'b0;
            settle();
            step();
            s_ack = 1'b1;
            settle();
            if (o_grant == 2'b10 && o_s_stb && o_s_we && o_s_addr == 32'h10 + 32'(4 * i))
                writes++;
            step();
        end
        idle_master(1);
        s_ack = 1'b0;
        for (int i = 0; i < 6; i++) begin
            settle();
            if (o_grant == 2'b01) break;
            step();
        end
        check("t3_writes_before_m0", 32'(writes), 32'd3);
        check("t3_m0_granted", o_grant, 2'b01);
        step();
        idle_master(0);
        step();
        step();

        // ---- Watchdog: M1 read that the slave never answers ----
        m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_we[1] = 1'b0; m_addr[1] = 32'h40;
        settle();
        stb_cycles = 0;
        for (int j = 0; j < TIMEOUT; j++) begin
            step();
            settle();
            if (o_s_stb) stb_cycles++;
        end
        check("t4_stb_cycles", 32'(stb_cycles), 32'd4);
        step();
        idle_master(1);
        s_ack = 1'b1;
        settle();
        check("t4_m1_err", m_err[1], 1'b1);
        check("t4_tout_s_cyc", o_s_cyc, 1'b0);
        check("t4_late_ack_tout", m_ack[1], 1'b0);
        check("t4_m0_err", m_err[0], 1'b0);
        step();
        settle();
        check("t4_late_ack_idle", m_ack[1], 1'b0);
        check("t4_err_one_cycle", m_err[1], 1'b0);
        check("t4_idle_grant", o_grant, 2'b00);
        step();
        s_ack = 1'b0;

        // ---- Randomized traffic, checked by the model every cycle ----
        hold[0]     = 0;
        hold[1]     = 0;
        stall       = 0;
        rst_pending = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            step();
            if (rst_pending) begin
                rst_n       = 1'b1;
                rst_pending = 1'b0;
            end
            for (int k = 0; k < 2; k++) begin
                if (hold[k] > 0) begin
                    hold[k]--;
                    if (hold[k] == 0) m_cyc[k] = 1'b0;
                end else if ($urandom_range(3) == 0) begin
                    m_cyc[k] = 1'b1;
                    hold[k]  = int'($urandom_range(10, 1));
                end
                m_stb[k]   = m_cyc[k] && ($urandom_range(3) != 0);
                m_we[k]    = 1'($urandom);
                m_addr[k]  = $urandom;
                m_wdata[k] = $urandom;
                m_sel[k]   = 4'($urandom);
            end
            s_rdata = $urandom;
            if (stall > 0) begin
                stall--;
                s_ack = 1'b0;
                s_err = 1'b0;
            end else begin
                int r;
                r     = int'($urandom_range(9));
                s_ack = (r < 4);
                s_err = (r == 4) || (r == 5 && $urandom_range(1) == 0);
                if (r == 9) stall = int'($urandom_range(8, 3));
            end
            if (c % 750 == 400) begin
                rst_n       = 1'b0;
                rst_pending = 1'b1;
            end
        end

        settle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
